// File: rtl/pkt_rr_sched.sv
// Packet-granular round-robin scheduler: drains two fallthrough packet FIFOs onto one
// AXI4-Stream master, holding each grant until the tlast handshake; keeps packet/byte stats.
module pkt_rr_sched #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic                              i_sched_en,
  input  logic                              i_cnt_clr,
  input  logic                              i_q0_empty,
  output logic                              o_q0_rd_en,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    i_q0_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   i_q0_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  i_q0_tkeep,
  input  logic                              i_q0_tlast,
  input  logic                              i_q1_empty,
  output logic                              o_q1_rd_en,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    i_q1_tdata,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   i_q1_tuser,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  i_q1_tkeep,
  input  logic                              i_q1_tlast,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]    o_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]   o_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  o_m_axis_tkeep,
  output logic                              o_m_axis_tlast,
  output logic                              o_m_axis_tvalid,
  input  logic                              i_m_axis_tready,
  output logic                              o_grant,
  output logic                              o_busy,
  output logic [CNT_WIDTH-1:0]              o_q0_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              o_q1_pkt_cnt,
  output logic [CNT_WIDTH-1:0]              o_byte_cnt
);

  localparam int unsigned KW = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned PW = $clog2(KW + 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e               state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 last_served_q, last_served_d;
  logic [CNT_WIDTH-1:0] q0_cnt_q, q0_cnt_d;
  logic [CNT_WIDTH-1:0] q1_cnt_q, q1_cnt_d;
  logic [CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic                 hs;
  logic [PW-1:0]        keep_pop;

  // Datapath mux and FIFO pops: combinational from flags and tready only
  always_comb begin
    o_m_axis_tdata  = '0;
    o_m_axis_tuser  = '0;
    o_m_axis_tkeep  = '0;
    o_m_axis_tlast  = 1'b0;
    o_m_axis_tvalid = 1'b0;
    if (state_q == SEND) begin
      if (grant_q) begin
        o_m_axis_tdata  = i_q1_tdata;
        o_m_axis_tuser  = i_q1_tuser;
        o_m_axis_tkeep  = i_q1_tkeep;
        o_m_axis_tlast  = i_q1_tlast;
        o_m_axis_tvalid = !i_q1_empty;
      end else begin
        o_m_axis_tdata  = i_q0_tdata;
        o_m_axis_tuser  = i_q0_tuser;
        o_m_axis_tkeep  = i_q0_tkeep;
        o_m_axis_tlast  = i_q0_tlast;
        o_m_axis_tvalid = !i_q0_empty;
      end
    end
    hs         = o_m_axis_tvalid & i_m_axis_tready;
    o_q0_rd_en = hs & !grant_q;
    o_q1_rd_en = hs & grant_q;
  end

  always_comb begin
    keep_pop = '0;
    for (int i = 0; i < KW; i++) keep_pop = keep_pop + PW'(o_m_axis_tkeep[i]);
  end

  // Arbitration: prefer the queue not served last; hold grant until tlast handshake
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_served_d = last_served_q;
    case (state_q)
      IDLE: begin
        if (i_sched_en && (!i_q0_empty || !i_q1_empty)) begin
          state_d = SEND;
          grant_d = (!i_q0_empty && !i_q1_empty) ? !last_served_q : i_q0_empty;
        end
      end
      SEND: begin
        if (hs && o_m_axis_tlast) begin
          last_served_d = grant_q;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Statistics; clear wins over a same-cycle increment
  always_comb begin
    q0_cnt_d   = q0_cnt_q;
    q1_cnt_d   = q1_cnt_q;
    byte_cnt_d = byte_cnt_q;
    if (hs) byte_cnt_d = byte_cnt_q + CNT_WIDTH'(keep_pop);
    if (hs && o_m_axis_tlast) begin
      if (grant_q) q1_cnt_d = q1_cnt_q + CNT_WIDTH'(1);
      else         q0_cnt_d = q0_cnt_q + CNT_WIDTH'(1);
    end
    if (i_cnt_clr) begin
      q0_cnt_d   = '0;
      q1_cnt_d   = '0;
      byte_cnt_d = '0;
    end
  end

  always_ff @(posedge axis_aclk) begin
    if (!axis_resetn) begin
      state_q       <= IDLE;
      grant_q       <= 1'b0;
      last_served_q <= 1'b1;
      q0_cnt_q      <= '0;
      q1_cnt_q      <= '0;
      byte_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_served_q <= last_served_d;
      q0_cnt_q      <= q0_cnt_d;
      q1_cnt_q      <= q1_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
    end
  end

  assign o_busy       = (state_q == SEND);
  assign o_grant      = grant_q;
  assign o_q0_pkt_cnt = q0_cnt_q;
  assign o_q1_pkt_cnt = q1_cnt_q;
  assign o_byte_cnt   = byte_cnt_q;

endmodule

// File: tb/tb_pkt_rr_sched.sv
// Scoreboard bench for pkt_rr_sched: modelled FIFOs feed the DUT, expected beats are
// queued in service order, and a negedge monitor checks every output beat and idle cycle.
`timescale 1ns/1ps
module tb_pkt_rr_sched;
  localparam int unsigned DW = 256;
  localparam int unsigned UW = 128;
  localparam int unsigned KW = DW / 8;
  // Narrow counters make the wrap boundary reachable in a short run
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic          q;
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic axis_resetn = 1'b0;
  logic i_sched_en = 1'b1, i_cnt_clr = 1'b0, i_m_axis_tready = 1'b1;
  logic i_q0_empty, i_q1_empty, i_q0_tlast, i_q1_tlast;
  logic [DW-1:0] i_q0_tdata, i_q1_tdata, o_m_axis_tdata;
  logic [UW-1:0] i_q0_tuser, i_q1_tuser, o_m_axis_tuser;
  logic [KW-1:0] i_q0_tkeep, i_q1_tkeep, o_m_axis_tkeep;
  logic o_q0_rd_en, o_q1_rd_en, o_m_axis_tlast, o_m_axis_tvalid, o_grant, o_busy;
  logic [CW-1:0] o_q0_pkt_cnt, o_q1_pkt_cnt, o_byte_cnt;

  beat_t f0[$], f1[$], exq[$];
  int n_tests = 0, n_fail = 0;
  int pops0 = 0, pops1 = 0;
  logic mon_en = 1'b0, pop0_r = 1'b0, pop1_r = 1'b0, rdy_toggle = 1'b0;
  logic prev_last_hs = 1'b0, prev_idle_req = 1'b0;

  pkt_rr_sched #(.C_S_AXIS_DATA_WIDTH(DW), .C_S_AXIS_TUSER_WIDTH(UW), .CNT_WIDTH(CW)) dut (
    .axis_aclk(clk), .axis_resetn(axis_resetn), .i_sched_en(i_sched_en), .i_cnt_clr(i_cnt_clr),
    .i_q0_empty(i_q0_empty), .o_q0_rd_en(o_q0_rd_en), .i_q0_tdata(i_q0_tdata),
    .i_q0_tuser(i_q0_tuser), .i_q0_tkeep(i_q0_tkeep), .i_q0_tlast(i_q0_tlast),
    .i_q1_empty(i_q1_empty), .o_q1_rd_en(o_q1_rd_en), .i_q1_tdata(i_q1_tdata),
    .i_q1_tuser(i_q1_tuser), .i_q1_tkeep(i_q1_tkeep), .i_q1_tlast(i_q1_tlast),
    .o_m_axis_tdata(o_m_axis_tdata), .o_m_axis_tuser(o_m_axis_tuser),
    .o_m_axis_tkeep(o_m_axis_tkeep), .o_m_axis_tlast(o_m_axis_tlast),
    .o_m_axis_tvalid(o_m_axis_tvalid), .i_m_axis_tready(i_m_axis_tready),
    .o_grant(o_grant), .o_busy(o_busy), .o_q0_pkt_cnt(o_q0_pkt_cnt),
    .o_q1_pkt_cnt(o_q1_pkt_cnt), .o_byte_cnt(o_byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input logic q, input int id, input int b, input int nb,
                               input logic [KW-1:0] lk);
    beat_t x;
    logic [31:0] w;
    w   = 32'(id * 256 + b) ^ 32'h5A00_0000 ^ (q ? 32'h0080_0000 : 32'h0);
    x.q = q;
    x.d = {8{w}};
    x.u = {4{~w}};
    x.k = (b == nb - 1) ? lk : {KW{1'b1}};
    x.l = (b == nb - 1);
    return x;
  endfunction

  task automatic refresh();
    beat_t h;
    i_q0_empty = (f0.size() == 0);
    h = (f0.size() != 0) ? f0[0] : '0;
    i_q0_tdata = h.d; i_q0_tuser = h.u; i_q0_tkeep = h.k; i_q0_tlast = h.l;
    i_q1_empty = (f1.size() == 0);
    h = (f1.size() != 0) ? f1[0] : '0;
    i_q1_tdata = h.d; i_q1_tuser = h.u; i_q1_tkeep = h.k; i_q1_tlast = h.l;
  endtask

  // Beats b0..b1 of an nb-beat packet, to the FIFO model and/or the expected queue
  task automatic add(input logic q, input int id, input int b0, input int b1, input int nb,
                     input logic [KW-1:0] lk, input bit to_f, input bit to_e);
    for (int b = b0; b <= b1; b++) begin
      if (to_f) begin
        if (q) f1.push_back(mk(q, id, b, nb, lk));
        else   f0.push_back(mk(q, id, b, nb, lk));
      end
      if (to_e) exq.push_back(mk(q, id, b, nb, lk));
    end
    refresh();
  endtask

  // FIFO model: apply pops sampled at the previous negedge
  always @(posedge clk) begin
    #1;
    if (pop0_r && f0.size() != 0) begin f0.delete(0); pops0++; end
    if (pop1_r && f1.size() != 0) begin f1.delete(0); pops1++; end
    pop0_r = 1'b0;
    pop1_r = 1'b0;
    if (rdy_toggle) i_m_axis_tready = !i_m_axis_tready;
    refresh();
  end

  // Monitor: scoreboard pop/compare on handshakes plus idle and bubble rules
  always @(negedge clk) begin
    if (mon_en) begin
      logic hs;
      logic [1:0] exp_rd;
      beat_t g, e;
      hs = o_m_axis_tvalid && i_m_axis_tready;
      pop0_r = o_q0_rd_en;
      pop1_r = o_q1_rd_en;
      exp_rd = 2'b00;
      if (!o_busy)
        chk("idle_quiet", 64'({o_m_axis_tvalid, o_q0_rd_en, o_q1_rd_en, |o_m_axis_tdata,
                               |o_m_axis_tuser, |o_m_axis_tkeep, o_m_axis_tlast}), 64'd0);
      if (hs) begin
        n_tests++;
        if (exq.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got data[31:0]=%h grant=%b expected no beat",
                   o_m_axis_tdata[31:0], o_grant);
        end else begin
          e = exq.pop_front();
          g = {o_grant, o_m_axis_tdata, o_m_axis_tuser, o_m_axis_tkeep, o_m_axis_tlast};
          exp_rd = e.q ? 2'b01 : 2'b10;
          if (g !== e) begin
            n_fail++;
            $display("FAIL beat: got q=%b d=%h k=%h l=%b expected q=%b d=%h k=%h l=%b",
                     g.q, g.d[31:0], g.k, g.l, e.q, e.d[31:0], e.k, e.l);
          end
        end
      end
      if (o_busy) chk("rd_en", 64'({o_q0_rd_en, o_q1_rd_en}), 64'(exp_rd));
      if (prev_last_hs) chk("gap_after_tlast", 64'(o_busy), 64'd0);
      else if (prev_idle_req) chk("grant_latency", 64'(o_busy), 64'd1);
      prev_last_hs  = hs && o_m_axis_tlast;
      prev_idle_req = !o_busy && i_sched_en && (!i_q0_empty || !i_q1_empty);
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    axis_resetn = 1'b0;
    f0.delete(); f1.delete(); exq.delete();
    pop0_r = 1'b0; pop1_r = 1'b0; pops0 = 0; pops1 = 0;
    prev_last_hs = 1'b0; prev_idle_req = 1'b0;
    rdy_toggle = 1'b0; i_m_axis_tready = 1'b1; i_sched_en = 1'b1; i_cnt_clr = 1'b0;
    refresh();
    repeat (2) @(posedge clk);
    #2;
    axis_resetn = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_ctrl", 64'({o_busy, o_grant, o_m_axis_tvalid, o_q0_rd_en, o_q1_rd_en}), 64'd0);
    chk("rst_cnts", 64'({o_q0_pkt_cnt, o_q1_pkt_cnt, o_byte_cnt}), 64'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c = 0;
    bit done = 1'b0;
    while (!done && c < budget) begin
      @(negedge clk);
      c++;
      done = (exq.size() == 0 && f0.size() == 0 && f1.size() == 0 && !o_busy);
    end
    chk({name, "_drained"}, 64'(done), 64'd1);
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    refresh();
    // 1: single 3-beat packet from q0
    do_reset();
    add(1'b0, 1, 0, 2, 3, '1, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_req_cycle_idle", 64'(o_busy), 64'd0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("t1_beat_ctl", 64'({o_busy, o_m_axis_tvalid, o_m_axis_tlast}), 64'({2'b11, b == 2}));
    end
    @(negedge clk);
    chk("t1_idle_after", 64'(o_busy), 64'd0);
    chk("t1_q0_pkts", 64'(o_q0_pkt_cnt), 64'd1);
    chk("t1_q1_pkts", 64'(o_q1_pkt_cnt), 64'd0);
    chk("t1_bytes", 64'(o_byte_cnt), 64'd96);

    // 2: two 2-beat packets per queue, alternating service starting with q0
    do_reset();
    add(1'b0, 2, 0, 1, 2, 32'h0000_FFFF, 1'b1, 1'b1);
    add(1'b1, 3, 0, 1, 2, 32'h0000_FFFF, 1'b1, 1'b1);
    add(1'b0, 4, 0, 1, 2, 32'h0000_FFFF, 1'b1, 1'b1);
    add(1'b1, 5, 0, 1, 2, 32'h0000_FFFF, 1'b1, 1'b1);
    wait_done("t2", 40);
    chk("t2_q0_pkts", 64'(o_q0_pkt_cnt), 64'd2);
    chk("t2_q1_pkts", 64'(o_q1_pkt_cnt), 64'd2);
    chk("t2_bytes", 64'(o_byte_cnt), 64'd192);

    // 3: q1 4-beat packet with toggling tready
    do_reset();
    add(1'b1, 6, 0, 3, 4, '1, 1'b1, 1'b1);
    rdy_toggle = 1'b1;
    wait_done("t3", 40);
    rdy_toggle = 1'b0;
    i_m_axis_tready = 1'b1;
    chk("t3_q1_pops", 64'(pops1), 64'd4);
    chk("t3_q0_pops", 64'(pops0), 64'd0);
    chk("t3_q1_pkts", 64'(o_q1_pkt_cnt), 64'd1);

    // 4: q0 packet runs dry after beat 2 for 5 cycles while q1 waits
    do_reset();
    add(1'b0, 10, 0, 3, 4, '1, 1'b0, 1'b1);
    add(1'b1, 11, 0, 2, 3, '1, 1'b0, 1'b1);
    add(1'b0, 10, 0, 1, 4, '1, 1'b1, 1'b0);
    add(1'b1, 11, 0, 2, 3, '1, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_stall", 64'({o_busy, o_grant, o_m_axis_tvalid}), 64'({1'b1, 1'b0, 1'b0}));
    end
    @(posedge clk);
    #2;
    add(1'b0, 10, 2, 3, 4, '1, 1'b1, 1'b0);
    wait_done("t4", 40);
    chk("t4_pkts", 64'({o_q0_pkt_cnt, o_q1_pkt_cnt}), 64'({8'd1, 8'd1}));

    // 5: scheduler disabled mid-packet, then re-enabled
    do_reset();
    add(1'b0, 20, 0, 3, 4, '1, 1'b1, 1'b1);
    add(1'b1, 21, 0, 1, 2, '1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    i_sched_en = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_held_idle", 64'(o_busy), 64'd0);
    end
    chk("t5_q1_untouched", 64'(f1.size()), 64'd2);
    chk("t5_q0_pkts", 64'(o_q0_pkt_cnt), 64'd1);
    @(posedge clk);
    #2;
    i_sched_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_reenable", 64'({o_busy, o_grant}), 64'({1'b1, 1'b1}));
    wait_done("t5", 20);

    // 6: byte counter near wrap, clear on the handshake cycle, then wrap
    do_reset();
    add(1'b0, 30, 0, 7, 8, 32'h0000_FFFF, 1'b1, 1'b1);
    wait_done("t6_preload", 30);
    chk("t6_preload_bytes", 64'(o_byte_cnt), 64'd240);
    add(1'b0, 31, 0, 0, 1, '1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    i_cnt_clr = 1'b1;
    @(posedge clk);
    #2;
    i_cnt_clr = 1'b0;
    @(negedge clk);
    chk("t6_clr_wins", 64'({o_q0_pkt_cnt, o_q1_pkt_cnt, o_byte_cnt}), 64'd0);
    wait_done("t6_clr", 20);
    add(1'b0, 32, 0, 7, 8, 32'h0000_FFFF, 1'b1, 1'b1);
    wait_done("t6_preload2", 30);
    add(1'b0, 33, 0, 0, 1, '1, 1'b1, 1'b1);
    wait_done("t6_wrap", 20);
    chk("t6_wrap_bytes", 64'(o_byte_cnt), 64'd16);
    chk("t6_wrap_pkts", 64'({o_q0_pkt_cnt, o_q1_pkt_cnt}), 64'({8'd2, 8'd0}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pkt_rr_sched.md
# pkt_rr_sched

Packet-granular round-robin scheduler that drains two fallthrough packet FIFOs (each filled by an input buffering stage) onto one AXI4-Stream master port. Grants are held for a whole packet, from the first beat to the `tlast` handshake, so packets are never interleaved. The block sits between the per-port input buffers and the downstream processing pipeline. It also keeps per-queue packet counters and a total byte counter.

## Interface
Parameters:
- `C_S_AXIS_DATA_WIDTH`, 256: beat data width in bits.
- `C_S_AXIS_TUSER_WIDTH`, 128: tuser width in bits.
- `CNT_WIDTH`, 32: width of every statistics counter.

Ports:
- `axis_aclk`  in  1  single clock; all logic on the rising edge.
- `axis_resetn`  in  1  synchronous, active-low reset.
- `i_sched_en`  in  1  1 = new grants allowed; 0 = finish the current packet, then hold in IDLE.
- `i_cnt_clr`  in  1  synchronous clear of all counters.
- `i_qN_empty`  in  1  FIFO N empty (N = 0, 1).
- `o_qN_rd_en`  out  1  pop FIFO N; the head word is consumed this cycle.
- `i_qN_tdata`  in  C_S_AXIS_DATA_WIDTH  FIFO N head data (fallthrough: valid while !empty).
- `i_qN_tuser`  in  C_S_AXIS_TUSER_WIDTH  FIFO N head tuser.
- `i_qN_tkeep`  in  C_S_AXIS_DATA_WIDTH/8  FIFO N head tkeep.
- `i_qN_tlast`  in  1  FIFO N head tlast.
- `o_m_axis_tdata`  out  C_S_AXIS_DATA_WIDTH  output data.
- `o_m_axis_tuser`  out  C_S_AXIS_TUSER_WIDTH  output tuser.
- `o_m_axis_tkeep`  out  C_S_AXIS_DATA_WIDTH/8  output tkeep.
- `o_m_axis_tlast`  out  1  output tlast.
- `o_m_axis_tvalid`  out  1  output valid.
- `i_m_axis_tready`  in  1  downstream ready.
- `o_grant`  out  1  index of the queue currently granted; meaningful in SEND.
- `o_busy`  out  1  1 while in SEND.
- `o_qN_pkt_cnt`  out  CNT_WIDTH  packets forwarded from queue N.
- `o_byte_cnt`  out  CNT_WIDTH  total bytes forwarded (sum of set tkeep bits).

## Operation
- States:
  - IDLE: no grant.
  - SEND: grant held on queue `o_grant`.
- IDLE → SEND when `i_sched_en`=1 and at least one queue is non-empty.
  - Pick the non-empty queue whose index differs from `last_served` first. If only one queue is non-empty, pick it.
  - Latch the choice into `o_grant`.
- In SEND:
  - `o_m_axis_tvalid` = !`i_q[o_grant]_empty`.
  - The data, tuser, tkeep and tlast outputs are a combinational mux of queue `o_grant`'s head word.
  - `o_q[o_grant]_rd_en` = tvalid & `i_m_axis_tready`. The other queue's rd_en is 0.
- A handshake with tlast=1: `last_served` ← `o_grant`, state → IDLE.
- An empty granted FIFO in the middle of a packet stalls: tvalid=0 and the grant is held. There is no timeout.
- `i_sched_en` falling during SEND has no effect until the current packet's tlast handshake.
- In IDLE: tvalid=0, both rd_en=0, and the data outputs are driven with 0.
- `last_served` resets to 1, so queue 0 wins the first simultaneous request.
- Counters:
  - `o_qN_pkt_cnt` increments on each tlast handshake from queue N.
  - `o_byte_cnt` adds popcount(tkeep) on every handshake.
  - All counters wrap modulo 2^CNT_WIDTH.
  - `i_cnt_clr` forces all counters to 0 that cycle. Clear takes precedence over any increment in the same cycle.
- Reset values:
  - state IDLE, `o_grant` 0, `last_served` 1.
  - `o_busy` 0, `o_m_axis_tvalid` 0, both rd_en 0, data outputs 0.
  - All counters 0.
- Reset asserted in the middle of a packet aborts it immediately. The remainder of that packet stays in its FIFO; flushing it is the source's responsibility.

## Timing
- Grant latency: one cycle. A queue going non-empty in IDLE at cycle t gives `o_busy`=1 and a valid first beat at t+1.
- Throughput is one beat per cycle while the head word is present and tready=1.
- There is exactly one IDLE cycle between consecutive packets, including packets from the same queue.
- tvalid, rd_en and the data outputs are combinational from FIFO flags and tready. There is no path from tready to tvalid.
- Counters update on the clock edge after the handshake.

## Test plan
- Reset, then q0 holds a 3-beat packet with tkeep=all-ones, tready=1. Required: beats at cycles 1–3 after the request, tlast on beat 3, `o_q0_pkt_cnt`=1, `o_byte_cnt`=96, then IDLE.
- Both queues each hold two 2-beat packets, tready=1. Required: order q0, q1, q0, q1, one bubble between packets, both packet counters = 2.
- q1 holds a 4-beat packet, tready toggles 1,0,1,0… Required: rd_en only in cycles where tready=1, 4 pops total, no beat duplicated or lost.
- q0 packet's FIFO goes empty after beat 2 for 5 cycles, while q1 holds a packet. Required: tvalid=0 during the gap, grant stays on q0, q1 is served only after q0's tlast.
- `i_sched_en` is dropped in the middle of a q0 packet while q1 is non-empty. Required: the q0 packet completes, then the block stays in IDLE. Re-asserting `i_sched_en` serves q1 next cycle.
- `o_byte_cnt` is preloaded to 2^32−16, then a 1-beat packet with 32 valid bytes is sent while `i_cnt_clr` is pulsed on the handshake cycle. Required: all counters read 0. Repeat without the clear: `o_byte_cnt` wraps to 16.
